dm_resp: RTL

DM_RESP -- requirements
Module: dm_resp

---
 rtl/dm_pkg.sv | 30 +++
 rtl/dm_ram.sv | 30 +++
 rtl/dm_resp.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory responder: access-size encodings,
// FSM state type, default memory depth and the alignment rule.
package dm_pkg;

    // Default log2 of the number of 32-bit words held by the responder.
    localparam int DEPTH_LOG2_DEF = 10;

    // Access-size encodings carried on the size port.
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    // Responder FSM states.
    typedef enum logic [2:0] {
        IDLE,
        RD,
        WR,
        MRG,
        RESP
    } state_t;

    // A request is rejected for the reserved size or for a misaligned half/word.
    function automatic logic req_illegal(input logic [1:0] size, input logic [1:0] lo);
        return (size == SZ_RSVD) ||
               ((size == SZ_HALF) && lo[0]) ||
               ((size == SZ_WORD) && (lo != 2'b00));
    endfunction

endpackage

// File: rtl/dm_ram.sv
// Single-port word memory: synchronous write, registered read, no byte
// enables. Contents are never reset.
module dm_ram #(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk_i,
    input  logic                  en_i,
    input  logic                  we_i,
    input  logic [DEPTH_LOG2-1:0] idx_i,
    input  logic [31:0]           wdata_i,
    output logic [31:0]           rdata_o
);

    logic [31:0] mem [0:(1 << DEPTH_LOG2) - 1];
    logic [31:0] rdata_q;

    // One access per enabled edge: either write the word or capture it for reading.
    always_ff @(posedge clk_i) begin
        if (en_i) begin
            if (we_i) begin
                mem[idx_i] <= wdata_i;
            end else begin
                rdata_q <= mem[idx_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dm_resp.sv
// Memory-side responder for the multicycle CPU data-memory interface.
// Accepts one request in IDLE, performs a read, a full-word write or a
// read-merge-write, and answers with a one-cycle ack carrying the extended
// load data or an address-error flag.
module dm_resp
    import dm_pkg::*;
#(
    parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        sign,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        ack,
    output logic [31:0] rdata,
    output logic        addr_err
);

    // Latched request and FSM state.
    state_t                state_q;
    logic                  we_q;
    logic [1:0]            size_q;
    logic                  sign_q;
    logic [DEPTH_LOG2+1:0] addr_q;
    logic [31:0]           wdata_q;
    logic                  mrg_ph_q;   // 0: merge read in flight, 1: merged write
    logic                  ack_q;
    logic                  err_q;

    // Memory port.
    logic                  ram_en;
    logic                  ram_we;
    logic [DEPTH_LOG2-1:0] ram_idx;
    logic [31:0]           ram_wdata;
    logic [31:0]           ram_rdata;
    logic [1:0]            lane;

    // Address bits above the memory span alias onto it and are intentionally dropped.
    logic                  unused_addr_hi;
    assign unused_addr_hi = ^addr[31:DEPTH_LOG2+2];

    // Select the addressed byte/half (little-endian) and extend it to 32 bits.
    function automatic logic [31:0] extend_load(input logic [31:0] word,
                                                input logic [1:0]  sz,
                                                input logic        sgn,
                                                input logic [1:0]  ln);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{ln, 3'b000} +: 8];
        h = ln[1] ? word[31:16] : word[15:0];
        case (sz)
            SZ_BYTE: r = {{24{sgn & b[7]}}, b};
            SZ_HALF: r = {{16{sgn & h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    // Replace only the addressed byte or half of the old word with store data.
    function automatic logic [31:0] merge_store(input logic [31:0] old,
                                                input logic [31:0] wd,
                                                input logic [1:0]  sz,
                                                input logic [1:0]  ln);
        logic [31:0] r;
        r = old;
        if (sz == SZ_BYTE) begin
            r[{ln, 3'b000} +: 8] = wd[7:0];
        end else begin
            r[{ln[1], 4'b0000} +: 16] = wd[15:0];
        end
        return r;
    endfunction

    assign lane    = addr_q[1:0];
    assign ram_idx = addr_q[DEPTH_LOG2+1:2];

    // Memory control: RD and the first MRG cycle read, WR and the second MRG cycle write.
    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_wdata = wdata_q;
        case (state_q)
            RD: begin
                ram_en = 1'b1;
            end
            WR: begin
                ram_en = 1'b1;
                ram_we = 1'b1;
            end
            MRG: begin
                ram_en    = 1'b1;
                ram_we    = mrg_ph_q;
                ram_wdata = merge_store(ram_rdata, wdata_q, size_q, lane);
            end
            default: begin
                ram_en = 1'b0;
            end
        endcase
    end

    dm_ram #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_ram (
        .clk_i  (clk),
        .en_i   (ram_en),
        .we_i   (ram_we),
        .idx_i  (ram_idx),
        .wdata_i(ram_wdata),
        .rdata_o(ram_rdata)
    );

    // Request FSM: accept in IDLE, sequence the memory access, pulse ack from RESP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            we_q     <= 1'b0;
            size_q   <= 2'b00;
            sign_q   <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= 32'h0;
            mrg_ph_q <= 1'b0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req) begin
                        we_q     <= we;
                        size_q   <= size;
                        sign_q   <= sign;
                        addr_q   <= addr[DEPTH_LOG2+1:0];
                        wdata_q  <= wdata;
                        mrg_ph_q <= 1'b0;
                        if (req_illegal(size, addr[1:0])) begin
                            // Rejected requests skip memory entirely.
                            state_q <= RESP;
                            ack_q   <= 1'b1;
                            err_q   <= 1'b1;
                        end else if (!we) begin
                            state_q <= RD;
                        end else if (size == SZ_WORD) begin
                            state_q <= WR;
                        end else begin
                            state_q <= MRG;
                        end
                    end
                end
                RD, WR: begin
                    state_q <= RESP;
                    ack_q   <= 1'b1;
                    err_q   <= 1'b0;
                end
                MRG: begin
                    if (!mrg_ph_q) begin
                        mrg_ph_q <= 1'b1;
                    end else begin
                        mrg_ph_q <= 1'b0;
                        state_q  <= RESP;
                        ack_q    <= 1'b1;
                        err_q    <= 1'b0;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                    ack_q   <= 1'b0;
                    err_q   <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    ack_q   <= 1'b0;
                    err_q   <= 1'b0;
                end
            endcase
        end
    end

    assign ack      = ack_q;
    assign addr_err = err_q;
    // Load data is only meaningful on a successful load ack; everything else reads zero.
    assign rdata    = (ack_q && !err_q && !we_q) ?
                      extend_load(ram_rdata, size_q, sign_q, lane) : 32'h0;

endmodule
